// File: rtl/event_or_monitor_if.sv
// event_or_monitor_if: channel inputs, control and event outputs of the OR/event monitor
interface event_or_monitor_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
);
    logic                 en;
    logic                 mode;
    logic [WIDTH-1:0]     match_val;
    logic [NCH*WIDTH-1:0] ch_data;
    logic                 irq_ack;
    logic                 cnt_clr;
    logic [WIDTH-1:0]     out_or;
    logic                 evt_pulse;
    logic                 irq;
    logic                 ovf;
    logic [CNT_W-1:0]     evt_count;
    modport master (
        output en, mode, match_val, ch_data, irq_ack, cnt_clr,
        input  out_or, evt_pulse, irq, ovf, evt_count
    );
    modport slave (
        input  en, mode, match_val, ch_data, irq_ack, cnt_clr,
        output out_or, evt_pulse, irq, ovf, evt_count
    );
endinterface

// File: rtl/event_or_monitor.sv
// event_or_monitor: registered OR of channels plus edge-detected match event, sticky irq/ovf and saturating counter
module event_or_monitor #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    event_or_monitor_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;
    logic [0:0]       state;
    logic [WIDTH-1:0] or_d;
    logic             any_eq, all_eq, cond, cond_q, evt;
    // OR-reduce the channels and evaluate the match condition on the live inputs
    always_comb begin
        or_d   = '0;
        any_eq = 1'b0;
        all_eq = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            or_d   = or_d | bus.ch_data[i*WIDTH +: WIDTH];
            any_eq = any_eq | (bus.ch_data[i*WIDTH +: WIDTH] == bus.match_val);
            all_eq = all_eq & (bus.ch_data[i*WIDTH +: WIDTH] == bus.match_val);
        end
        cond = bus.mode ? all_eq : any_eq;
        evt  = bus.en && cond && !cond_q;
    end
    // Datapath and edge-detect history update every cycle regardless of en
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_or    <= '0;
            cond_q        <= 1'b0;
            bus.evt_pulse <= 1'b0;
        end else begin
            bus.out_or    <= or_d;
            cond_q        <= cond;
            bus.evt_pulse <= evt;
        end
    end
    // Saturating event counter; a clear coinciding with an event counts that event
    always_ff @(posedge clk) begin
        if (rst)
            bus.evt_count <= '0;
        else if (bus.cnt_clr)
            bus.evt_count <= CNT_W'(evt);
        else if (evt && bus.evt_count != '1)
            bus.evt_count <= bus.evt_count + 1'b1;
    end
    // Interrupt FSM: an event while pending without ack flags overrun; ack clears overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bus.ovf <= 1'b0;
        end else if (state == IDLE) begin
            if (evt)
                state <= PEND;
        end else if (bus.irq_ack) begin
            state   <= evt ? PEND : IDLE;
            bus.ovf <= 1'b0;
        end else if (evt) begin
            bus.ovf <= 1'b1;
        end
    end
    assign bus.irq = (state == PEND);
endmodule

// File: tb/tb_event_or_monitor.sv
// tb_event_or_monitor: directed checks of event_or_monitor with CNT_W=8 and a CNT_W=2 instance
module tb_event_or_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        mode = 1'b0;
    logic [7:0]  mv = 8'hFF;
    logic [15:0] ch = 16'hFFFF;
    logic        ack = 1'b0;
    logic        clr = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          npulse;
    event_or_monitor_if #(.WIDTH(8), .NCH(2), .CNT_W(8)) ia ();
    event_or_monitor_if #(.WIDTH(8), .NCH(2), .CNT_W(2)) ib ();
    assign ia.en = en;
    assign ia.mode = mode;
    assign ia.match_val = mv;
    assign ia.ch_data = ch;
    assign ia.irq_ack = ack;
    assign ia.cnt_clr = clr;
    assign ib.en = en;
    assign ib.mode = mode;
    assign ib.match_val = mv;
    assign ib.ch_data = ch;
    assign ib.irq_ack = ack;
    assign ib.cnt_clr = clr;
    event_or_monitor #(.WIDTH(8), .NCH(2), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    event_or_monitor #(.WIDTH(8), .NCH(2), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    initial begin
        tick();
        tick();
        check("rst_out_or", 32'(ia.out_or), 32'h0);
        check("rst_pulse", 32'(ia.evt_pulse), 32'h0);
        check("rst_irq", 32'(ia.irq), 32'h0);
        check("rst_ovf", 32'(ia.ovf), 32'h0);
        check("rst_count", 32'(ia.evt_count), 32'h0);
        rst = 1'b0;
        tick();
        check("first_pulse", 32'(ia.evt_pulse), 32'h1);
        check("first_irq", 32'(ia.irq), 32'h1);
        check("first_count", 32'(ia.evt_count), 32'h1);
        check("first_out_or", 32'(ia.out_or), 32'hFF);
        tick();
        check("held_pulse", 32'(ia.evt_pulse), 32'h0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_irq", 32'(ia.irq), 32'h0);
        ch = 16'hA00F;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("or_out", 32'(ia.out_or), 32'hAF);
        check("or_no_pulse", 32'(ia.evt_pulse), 32'h0);
        check("clr_count", 32'(ia.evt_count), 32'h0);
        ch = 16'h00FF;
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            npulse += int'(ia.evt_pulse);
        end
        check("hold_npulse", 32'(npulse), 32'h1);
        check("hold_count", 32'(ia.evt_count), 32'h1);
        check("hold_irq", 32'(ia.irq), 32'h1);
        ch = 16'h0000;
        tick();
        check("drop_out_or", 32'(ia.out_or), 32'h00);
        ch = 16'h00FF;
        tick();
        check("rerise_pulse", 32'(ia.evt_pulse), 32'h1);
        check("rerise_count", 32'(ia.evt_count), 32'h2);
        check("ovf_set", 32'(ia.ovf), 32'h1);
        check("ovf_irq", 32'(ia.irq), 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_alone_irq", 32'(ia.irq), 32'h0);
        check("ack_alone_ovf", 32'(ia.ovf), 32'h0);
        mode = 1'b1;
        ch = 16'h7FFF;
        tick();
        check("all_partial_pulse", 32'(ia.evt_pulse), 32'h0);
        check("all_partial_irq", 32'(ia.irq), 32'h0);
        ch = 16'hFFFF;
        tick();
        check("all_full_pulse", 32'(ia.evt_pulse), 32'h1);
        check("all_full_irq", 32'(ia.irq), 32'h1);
        check("all_full_count", 32'(ia.evt_count), 32'h3);
        ch = 16'h7FFF;
        tick();
        ch = 16'hFFFF;
        tick();
        check("ovf2_set", 32'(ia.ovf), 32'h1);
        check("ovf2_count", 32'(ia.evt_count), 32'h4);
        ch = 16'h7FFF;
        tick();
        ch = 16'hFFFF;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ackevt_irq", 32'(ia.irq), 32'h1);
        check("ackevt_ovf", 32'(ia.ovf), 32'h0);
        check("ackevt_pulse", 32'(ia.evt_pulse), 32'h1);
        check("count_a5", 32'(ia.evt_count), 32'h5);
        check("count_b_sat", 32'(ib.evt_count), 32'h3);
        ch = 16'h7FFF;
        tick();
        ch = 16'hFFFF;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_evt_a", 32'(ia.evt_count), 32'h1);
        check("clr_evt_b", 32'(ib.evt_count), 32'h1);
        mode = 1'b0;
        ch = 16'h7F7E;
        tick();
        check("nomatch_out_or", 32'(ia.out_or), 32'h7F);
        en = 1'b0;
        ch = 16'h01FF;
        tick();
        check("en0_pulse", 32'(ia.evt_pulse), 32'h0);
        check("en0_count", 32'(ia.evt_count), 32'h1);
        check("en0_out_or", 32'(ia.out_or), 32'hFF);
        en = 1'b1;
        tick();
        check("en1_held_pulse", 32'(ia.evt_pulse), 32'h0);
        check("en1_held_count", 32'(ia.evt_count), 32'h1);
        rst = 1'b1;
        tick();
        check("midpend_rst_irq", 32'(ia.irq), 32'h0);
        check("midpend_rst_ovf", 32'(ia.ovf), 32'h0);
        check("midpend_rst_count", 32'(ia.evt_count), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
